microroc_sc_loader: RTL

Slow-control loader for the MICROROC ASIC. Sits directly upstream of the S-curve test controller's configuration interface. It accepts that controller's one-cycle parameter-load request together with the 10-bit DAC code and 64-bit CTest channel mask. It builds the full slow-control frame, resets and serially shifts the frame into the ASIC's slow-control register, captures the bits shifted out, and returns a one-cycle config-done pulse.

---
 rtl/microroc_sc_loader.sv | 116 +++++++++++
 1 files changed

// File: rtl/microroc_sc_loader.sv
`timescale 1ns/1ps
// Slow-control loader for MICROROC: builds the configuration frame, resets the ASIC
// slow-control register and shifts the frame in MSB first while reading the old contents back.
module microroc_sc_loader #(
    parameter int SC_BITS   = 592,
    parameter int CLK_DIV   = 4,
    parameter int RST_CYC   = 8,
    parameter int DAC_LSB   = 20,
    parameter int CTEST_LSB = 528
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sc_param_load,
    input  logic [9:0]         dac_code,
    input  logic [63:0]        ctest_chn,
    input  logic [SC_BITS-1:0] sc_base,
    input  logic               sr_out,
    output logic               sr_ck,
    output logic               sr_in,
    output logic               sr_rstb,
    output logic               busy,
    output logic               config_done,
    output logic [SC_BITS-1:0] rb_frame
);

    localparam int BIT_W = $clog2(SC_BITS + 1);
    localparam int PH_W  = $clog2(CLK_DIV + 1);
    localparam int RST_W = $clog2(RST_CYC + 1);

    typedef enum logic [1:0] {IDLE, RSTB, SHIFT, DONE} state_t;

    state_t             state;
    logic [BIT_W-1:0]   bit_cnt;
    logic [PH_W-1:0]    ph_cnt;
    logic [RST_W-1:0]   rst_cnt;
    logic [SC_BITS-1:0] frame;
    logic [SC_BITS-1:0] rb_shift;
    logic [SC_BITS-1:0] frame_in;

    // NOTE: every variable gets a default first, so no path through the block infers a latch.
    always_comb begin
        frame_in = sc_base;
        frame_in[DAC_LSB +: 10]   = dac_code;
        frame_in[CTEST_LSB +: 64] = ctest_chn;
    end

    // NOTE: state is updated with <= only, so all flops see pre-edge values of each other.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            ph_cnt      <= '0;
            rst_cnt     <= '0;
            frame       <= '0;
            rb_shift    <= '0;
            rb_frame    <= '0;
            sr_ck       <= 1'b0;
            sr_in       <= 1'b0;
            sr_rstb     <= 1'b1;
            busy        <= 1'b0;
            config_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sc_param_load) begin
                        frame   <= frame_in;
                        bit_cnt <= '0;
                        rst_cnt <= '0;
                        busy    <= 1'b1;
                        sr_rstb <= 1'b0;
                        state   <= RSTB;
                    end
                end
                RSTB: begin
                    if (rst_cnt == RST_W'(RST_CYC - 1)) begin
                        sr_rstb <= 1'b1;
                        sr_ck   <= 1'b0;
                        sr_in   <= frame[SC_BITS-1];
                        ph_cnt  <= '0;
                        state   <= SHIFT;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (ph_cnt == PH_W'(CLK_DIV - 1)) begin
                        ph_cnt <= '0;
                        sr_ck  <= ~sr_ck;
                        if (!sr_ck) begin
                            // sr_out still shows the bit the ASIC will push out on this rising edge
                            rb_shift <= {rb_shift[SC_BITS-2:0], sr_out};
                        end else if (bit_cnt == BIT_W'(SC_BITS - 1)) begin
                            sr_in       <= 1'b0;
                            rb_frame    <= rb_shift;
                            config_done <= 1'b1;
                            state       <= DONE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            frame   <= frame << 1;
                            sr_in   <= frame[SC_BITS-2];
                        end
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                DONE: begin
                    config_done <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
